// File: rtl/test_pattern_gen_v6_if.sv
// Sample-stream bundle shared by the input and output sides of the
// test pattern generator.
//   data_valid     : word qualifier
//   data           : P*C samples, slice c*P+k is channel c lane k (lane 0 oldest)
//   trigger_vector : P*C trigger bits, same indexing as data
// master drives the bundle, slave receives it.
interface test_pattern_gen_v6_if #(
  parameter int BITSPERSAMPLE             = 16,
  parameter int PARALLELSAMPLESPERCHANNEL = 2,
  parameter int CHANNELS                  = 2
);
  localparam int LANES = PARALLELSAMPLESPERCHANNEL * CHANNELS;

  logic                           data_valid;
  logic [LANES*BITSPERSAMPLE-1:0] data;
  logic [LANES-1:0]               trigger_vector;

  modport master (output data_valid, data, trigger_vector);
  modport slave  (input  data_valid, data, trigger_vector);
endinterface

// File: rtl/test_pattern_gen_v6.sv
// Test pattern generator placed between ADC capture and trigger logic.
// Per channel it either passes the captured samples through or replaces
// them with a synthetic pattern (up / down / triangle counter with
// programmable wrap, constant, PRBS-15). A periodic trigger vector aligned
// to the pattern can replace the incoming trigger bits. All outputs are
// registered with one cycle of latency.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   en_i              : pattern advance enable (with in_if.data_valid)
//   pattern_mode_i    : 0 pass, 1 up, 2 down, 3 triangle, 4 const, 5 PRBS (6-7 = pass)
//   ch_select_i       : per channel, 1 = pattern, 0 = passthrough
//   counter_max_i     : counter wrap value M
//   constant_value_i  : signed constant for mode 4
//   trig_en_i         : 1 = generated trigger, 0 = pass trigger through
//   trig_period_i     : trigger period N in samples (0 = no triggers)
//   in_if  (slave)    : incoming sample word / valid / triggers
//   out_if (master)   : outgoing sample word / valid / triggers
module test_pattern_gen_v6 #(
  parameter int BITSPERSAMPLE             = 16,
  parameter int PARALLELSAMPLESPERCHANNEL = 2,
  parameter int CHANNELS                  = 2,
  parameter int TRIGPERIODWIDTH           = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic [2:0]                  pattern_mode_i,
  input  logic [CHANNELS-1:0]         ch_select_i,
  input  logic [BITSPERSAMPLE-1:0]    counter_max_i,
  input  logic signed [15:0]          constant_value_i,
  input  logic                        trig_en_i,
  input  logic [TRIGPERIODWIDTH-1:0]  trig_period_i,
  test_pattern_gen_v6_if.slave        in_if,
  test_pattern_gen_v6_if.master       out_if
);

  localparam int B   = BITSPERSAMPLE;
  localparam int P   = PARALLELSAMPLESPERCHANNEL;
  localparam int C   = CHANNELS;
  localparam int TPW = TRIGPERIODWIDTH;
  localparam int L   = P * C;
  // Phase must hold values up to 2M-1 for the triangle.
  localparam int PW  = B + 1;
  // Working width: room for 2M plus lane offsets without overflow.
  localparam int CW  = ((B > TPW) ? B : TPW) + 5;

  typedef enum logic [2:0] {
    MODE_PASS  = 3'd0,
    MODE_UP    = 3'd1,
    MODE_DOWN  = 3'd2,
    MODE_TRI   = 3'd3,
    MODE_CONST = 3'd4,
    MODE_PRBS  = 3'd5
  } mode_e;

  typedef logic [CW-1:0] wide_t;

  // Reduce val into 0..modulus-1. Callers guarantee val < modulus + P, so
  // at most P conditional subtractions are ever needed, which also covers
  // the short-range case modulus < P. A zero modulus yields 0.
  function automatic wide_t wrap_mod(input wide_t val, input wide_t modulus);
    wide_t r;
    r = val;
    if (modulus == '0) begin
      r = '0;
    end else begin
      for (int i = 0; i < P; i++) begin
        if (r >= modulus) r = r - modulus;
      end
    end
    return r;
  endfunction

  // Fibonacci LFSR x^15 + x^14 + 1, shifting left.
  function automatic logic [14:0] lfsr_step(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  // Triangle fold: rising for s <= M, falling back toward 0 above it.
  function automatic wide_t tri_fold(input wide_t s, input wide_t m, input wide_t period);
    return (s <= m) ? s : (period - s);
  endfunction

  function automatic logic [B-1:0] to_sample(input wide_t v);
    return v[B-1:0];
  endfunction

  function automatic logic [PW-1:0] to_phase(input wide_t v);
    return v[PW-1:0];
  endfunction

  function automatic logic [TPW-1:0] to_tcnt(input wide_t v);
    return v[TPW-1:0];
  endfunction

  // PRBS state zero-extended, or its low bits when the sample is narrower.
  function automatic logic [B-1:0] prbs_sample(input logic [14:0] s);
    logic [B+14:0] w;
    w = {{B{1'b0}}, s};
    return w[B-1:0];
  endfunction

  // Constant sign-extended, or truncated when the sample is narrower.
  function automatic logic [B-1:0] const_sample(input logic signed [15:0] v);
    logic signed [B+15:0] w;
    w = {{B{v[15]}}, v};
    return w[B-1:0];
  endfunction

  function automatic mode_e norm_mode(input logic [2:0] m);
    return (m > 3'd5) ? MODE_PASS : mode_e'(m);
  endfunction

  mode_e            mode_q, mode_n, mode_in;
  logic [PW-1:0]    phase_q, phase_n;
  logic [14:0]      lfsr_q, lfsr_n;
  logic [TPW-1:0]   tcnt_q, tcnt_n;
  logic             trig_en_q;

  logic             advance;
  wide_t            cmax, up_mod, tri_mod, phase_cur, phase_adv;
  wide_t            per, t_cur, t_adv;
  logic [14:0]      lfsr_lane [0:P];
  logic [B-1:0]     pat_lane  [0:P-1];
  logic [P-1:0]     trig_lane;
  logic [L*B-1:0]   data_nxt;
  logic [L-1:0]     trig_nxt;

  logic [L*B-1:0]   data_p0;
  logic [L-1:0]     trig_p0;
  logic             vld_p0;

  always_comb begin
    mode_in   = norm_mode(pattern_mode_i);
    mode_n    = mode_in;
    advance   = en_i && in_if.data_valid;
    cmax      = wide_t'(counter_max_i);
    up_mod    = cmax + wide_t'(1);
    tri_mod   = cmax << 1;

    // A mode change restarts the pattern in the same cycle, so the word
    // produced now already shows the new mode's start value.
    phase_cur    = (mode_in != mode_q) ? '0 : wide_t'(phase_q);
    lfsr_lane[0] = (mode_in != mode_q) ? 15'h7FFF : lfsr_q;
    for (int k = 0; k < P; k++) begin
      lfsr_lane[k+1] = lfsr_step(lfsr_lane[k]);
    end

    // Shrinking M can leave the phase outside the range; restart at 0.
    if (mode_in == MODE_TRI) begin
      if (phase_cur >= tri_mod) phase_cur = '0;
    end else begin
      if (phase_cur > cmax) phase_cur = '0;
    end

    for (int k = 0; k < P; k++) begin
      pat_lane[k] = '0;
      case (mode_in)
        MODE_UP:    pat_lane[k] = to_sample(wrap_mod(phase_cur + wide_t'(k), up_mod));
        MODE_DOWN:  pat_lane[k] = counter_max_i
                                  - to_sample(wrap_mod(phase_cur + wide_t'(k), up_mod));
        MODE_TRI:   pat_lane[k] = to_sample(tri_fold(wrap_mod(phase_cur + wide_t'(k), tri_mod),
                                                     cmax, tri_mod));
        MODE_CONST: pat_lane[k] = const_sample(constant_value_i);
        MODE_PRBS:  pat_lane[k] = prbs_sample(lfsr_lane[k]);
        default:    pat_lane[k] = '0;
      endcase
    end

    phase_adv = (mode_in == MODE_TRI) ? wrap_mod(phase_cur + wide_t'(P), tri_mod)
                                      : wrap_mod(phase_cur + wide_t'(P), up_mod);
    phase_n   = to_phase(phase_cur);
    lfsr_n    = lfsr_lane[0];
    if (advance) begin
      if (mode_in == MODE_UP || mode_in == MODE_DOWN || mode_in == MODE_TRI) begin
        phase_n = to_phase(phase_adv);
      end
      if (mode_in == MODE_PRBS) begin
        lfsr_n = lfsr_lane[P];
      end
    end

    // Trigger counter restarts on a trig_en rising edge; an out-of-range
    // count (period shrunk, or N=0) collapses to 0.
    per   = wide_t'(trig_period_i);
    t_cur = (trig_en_i && !trig_en_q) ? '0 : wide_t'(tcnt_q);
    if (t_cur >= per) t_cur = '0;
    for (int k = 0; k < P; k++) begin
      trig_lane[k] = (per != '0) && (wrap_mod(t_cur + wide_t'(k), per) == '0);
    end
    t_adv  = wrap_mod(t_cur + wide_t'(P), per);
    tcnt_n = to_tcnt(t_cur);
    if (trig_en_i && advance) begin
      tcnt_n = to_tcnt(t_adv);
    end

    data_nxt = in_if.data;
    trig_nxt = in_if.trigger_vector;
    for (int c = 0; c < C; c++) begin
      for (int k = 0; k < P; k++) begin
        if (mode_in != MODE_PASS && ch_select_i[c]) begin
          data_nxt[(c*P+k)*B +: B] = pat_lane[k];
        end
        if (trig_en_i) begin
          trig_nxt[c*P+k] = trig_lane[k];
        end
      end
    end
  end

  // Stage p0: state update and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q    <= mode_in;
      phase_q   <= '0;
      lfsr_q    <= 15'h7FFF;
      tcnt_q    <= '0;
      trig_en_q <= 1'b0;
      data_p0   <= '0;
      trig_p0   <= '0;
      vld_p0    <= 1'b0;
    end else begin
      mode_q    <= mode_n;
      phase_q   <= phase_n;
      lfsr_q    <= lfsr_n;
      tcnt_q    <= tcnt_n;
      trig_en_q <= trig_en_i;
      data_p0   <= data_nxt;
      trig_p0   <= trig_nxt;
      vld_p0    <= in_if.data_valid;
    end
  end

  assign out_if.data           = data_p0;
  assign out_if.trigger_vector = trig_p0;
  assign out_if.data_valid     = vld_p0;

endmodule

// File: tb/tb_test_pattern_gen_v6.sv
module tb_test_pattern_gen_v6;
  localparam int B   = 16;
  localparam int P   = 2;
  localparam int C   = 2;
  localparam int TPW = 16;
  localparam int L   = P * C;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic [2:0]          mode;
  logic [C-1:0]        ch_sel;
  logic [B-1:0]        cmax;
  logic signed [15:0]  cval;
  logic                trig_en;
  logic [TPW-1:0]      tper;

  test_pattern_gen_v6_if #(.BITSPERSAMPLE(B), .PARALLELSAMPLESPERCHANNEL(P), .CHANNELS(C)) in_if ();
  test_pattern_gen_v6_if #(.BITSPERSAMPLE(B), .PARALLELSAMPLESPERCHANNEL(P), .CHANNELS(C)) out_if ();

  test_pattern_gen_v6 #(
    .BITSPERSAMPLE(B), .PARALLELSAMPLESPERCHANNEL(P), .CHANNELS(C), .TRIGPERIODWIDTH(TPW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .en_i             (en),
    .pattern_mode_i   (mode),
    .ch_select_i      (ch_sel),
    .counter_max_i    (cmax),
    .constant_value_i (cval),
    .trig_en_i        (trig_en),
    .trig_period_i    (tper),
    .in_if            (in_if),
    .out_if           (out_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [L*B-1:0] data;
    logic [L-1:0]   trig;
    logic           vld;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Channel A lanes (a0,a1), channel B lanes (b0,b1); slice 0 is chA lane 0.
  function automatic logic [L*B-1:0] pk(input logic [15:0] a0, input logic [15:0] a1,
                                        input logic [15:0] b0, input logic [15:0] b1);
    return {b1, b0, a1, a0};
  endfunction

  task automatic step(input exp_t e);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] m);
    rst = 1'b1; mode = m; en = 1'b1; ch_sel = 2'b11; cmax = 16'd5; cval = 16'sd0;
    trig_en = 1'b0; tper = 16'd3;
    in_if.data_valid = 1'b1; in_if.data = '0; in_if.trigger_vector = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e, got;
    rst = 1'b1; mode = 3'd1; en = 1'b1; ch_sel = 2'b11; cmax = 16'd5; cval = 16'sd7;
    trig_en = 1'b0; tper = 16'd3;
    in_if.data_valid = 1'b1; in_if.data = '1; in_if.trigger_vector = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      e = '{data: '0, trig: '0, vld: 1'b0};
      step(e);
      got = sb.pop_front();
      n_checks++;
      if ({out_if.data, out_if.trigger_vector, out_if.data_valid} !== got) begin
        n_fail++;
        $display("FAIL reset[%0d]: got data=%h trig=%b vld=%b, expected data=%h trig=%b vld=%b",
                 i, out_if.data, out_if.trigger_vector, out_if.data_valid, got.data, got.trig, got.vld);
      end
    end
  endtask

  task automatic test_up();
    exp_t e, got;
    logic [15:0] lo [4];
    lo[0] = 0; lo[1] = 2; lo[2] = 4; lo[3] = 0;
    rst = 1'b0; in_if.data = '0; in_if.trigger_vector = '0;
    for (int i = 0; i < 4; i++) begin
      e = '{data: pk(lo[i], lo[i]+16'd1, lo[i], lo[i]+16'd1), trig: '0, vld: 1'b1};
      step(e);
      got = sb.pop_front();
      n_checks++;
      if ({out_if.data, out_if.trigger_vector, out_if.data_valid} !== got) begin
        n_fail++;
        $display("FAIL up[%0d]: got data=%h trig=%b vld=%b, expected data=%h trig=%b vld=%b",
                 i, out_if.data, out_if.trigger_vector, out_if.data_valid, got.data, got.trig, got.vld);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e, got;
    logic        en_t [8];
    logic        dv_t [8];
    logic [15:0] lo   [8];
    en_t = '{1, 0, 0, 1, 1, 1, 1, 1};
    dv_t = '{1, 1, 1, 1, 1, 0, 1, 1};
    lo   = '{0, 2, 2, 2, 4, 0, 0, 2};
    do_reset(3'd1);
    for (int i = 0; i < 8; i++) begin
      en = en_t[i];
      in_if.data_valid = dv_t[i];
      e = '{data: pk(lo[i], lo[i]+16'd1, lo[i], lo[i]+16'd1), trig: '0, vld: dv_t[i]};
      step(e);
      got = sb.pop_front();
      n_checks++;
      if ({out_if.data, out_if.trigger_vector, out_if.data_valid} !== got) begin
        n_fail++;
        $display("FAIL hold[%0d]: got data=%h trig=%b vld=%b, expected data=%h trig=%b vld=%b",
                 i, out_if.data, out_if.trigger_vector, out_if.data_valid, got.data, got.trig, got.vld);
      end
    end
  endtask

  task automatic test_triangle_passthrough();
    exp_t e, got;
    logic [2:0]     m_t  [8];
    logic [15:0]    mx_t [8];
    logic [1:0]     ch_t [8];
    logic [L*B-1:0] din  [8];
    logic [L*B-1:0] ex   [8];
    m_t  = '{3, 3, 3, 3, 3, 3, 0, 7};
    mx_t = '{3, 3, 3, 3, 3, 0, 0, 0};
    ch_t = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11};
    for (int i = 0; i < 8; i++) din[i] = '0;
    din[4] = pk(16'h1111, 16'h1111, 16'hABCD, 16'hABCD);
    din[6] = 64'h0123_4567_89AB_CDEF;
    din[7] = 64'hFEDC_BA98_7654_3210;
    ex[0] = pk(0, 1, 0, 1);
    ex[1] = pk(2, 3, 2, 3);
    ex[2] = pk(2, 1, 2, 1);
    ex[3] = pk(0, 1, 0, 1);
    ex[4] = pk(2, 3, 16'hABCD, 16'hABCD);
    ex[5] = pk(0, 0, 0, 0);
    ex[6] = 64'h0123_4567_89AB_CDEF;
    ex[7] = 64'hFEDC_BA98_7654_3210;
    do_reset(3'd3);
    for (int i = 0; i < 8; i++) begin
      mode = m_t[i]; cmax = mx_t[i]; ch_sel = ch_t[i]; in_if.data = din[i];
      e = '{data: ex[i], trig: '0, vld: 1'b1};
      step(e);
      got = sb.pop_front();
      n_checks++;
      if ({out_if.data, out_if.trigger_vector, out_if.data_valid} !== got) begin
        n_fail++;
        $display("FAIL tri_pass[%0d]: got data=%h trig=%b vld=%b, expected data=%h trig=%b vld=%b",
                 i, out_if.data, out_if.trigger_vector, out_if.data_valid, got.data, got.trig, got.vld);
      end
    end
  endtask

  task automatic test_prbs_const();
    exp_t e, got;
    logic [2:0]     m_t [4];
    logic [1:0]     ch_t[4];
    logic [L*B-1:0] din [4];
    logic [L*B-1:0] ex  [4];
    m_t  = '{5, 5, 4, 5};
    ch_t = '{2'b11, 2'b11, 2'b11, 2'b10};
    din[0] = '0; din[1] = '0; din[2] = '0;
    din[3] = pk(16'h1234, 16'h5678, 16'h0, 16'h0);
    ex[0] = pk(16'h7FFF, 16'h7FFE, 16'h7FFF, 16'h7FFE);
    ex[1] = pk(16'h7FFC, 16'h7FF8, 16'h7FFC, 16'h7FF8);
    ex[2] = pk(16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE);
    ex[3] = pk(16'h1234, 16'h5678, 16'h7FFF, 16'h7FFE);
    do_reset(3'd5);
    cval = -16'sd2;
    for (int i = 0; i < 4; i++) begin
      mode = m_t[i]; ch_sel = ch_t[i]; in_if.data = din[i];
      e = '{data: ex[i], trig: '0, vld: 1'b1};
      step(e);
      got = sb.pop_front();
      n_checks++;
      if ({out_if.data, out_if.trigger_vector, out_if.data_valid} !== got) begin
        n_fail++;
        $display("FAIL prbs_const[%0d]: got data=%h trig=%b vld=%b, expected data=%h trig=%b vld=%b",
                 i, out_if.data, out_if.trigger_vector, out_if.data_valid, got.data, got.trig, got.vld);
      end
    end
  endtask

  task automatic test_trigger();
    exp_t e, got;
    logic        te_t [8];
    logic [15:0] n_t  [8];
    logic [3:0]  ex_t [8];
    te_t = '{1, 1, 1, 1, 1, 1, 0, 1};
    n_t  = '{3, 3, 3, 3, 0, 0, 3, 3};
    ex_t = '{4'b0101, 4'b1010, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b1001, 4'b0101};
    do_reset(3'd0);
    in_if.data = 64'h5555_AAAA_3C3C_C3C3;
    in_if.trigger_vector = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      trig_en = te_t[i]; tper = n_t[i];
      e = '{data: 64'h5555_AAAA_3C3C_C3C3, trig: ex_t[i], vld: 1'b1};
      step(e);
      got = sb.pop_front();
      n_checks++;
      if ({out_if.data, out_if.trigger_vector, out_if.data_valid} !== got) begin
        n_fail++;
        $display("FAIL trigger[%0d]: got data=%h trig=%b vld=%b, expected data=%h trig=%b vld=%b",
                 i, out_if.data, out_if.trigger_vector, out_if.data_valid, got.data, got.trig, got.vld);
      end
    end
  endtask

  task automatic test_mode_switch_reset();
    exp_t e, got;
    logic [2:0]     m_t [7];
    logic           r_t [7];
    logic [L*B-1:0] ex  [7];
    m_t = '{1, 1, 2, 2, 1, 1, 1};
    r_t = '{0, 0, 0, 0, 1, 0, 0};
    ex[0] = pk(0, 1, 0, 1);
    ex[1] = pk(2, 3, 2, 3);
    ex[2] = pk(5, 4, 5, 4);
    ex[3] = pk(3, 2, 3, 2);
    ex[4] = '0;
    ex[5] = pk(0, 1, 0, 1);
    ex[6] = pk(2, 3, 2, 3);
    do_reset(3'd1);
    for (int i = 0; i < 7; i++) begin
      mode = m_t[i]; rst = r_t[i];
      e = '{data: ex[i], trig: '0, vld: !r_t[i]};
      step(e);
      got = sb.pop_front();
      n_checks++;
      if ({out_if.data, out_if.trigger_vector, out_if.data_valid} !== got) begin
        n_fail++;
        $display("FAIL mode_rst[%0d]: got data=%h trig=%b vld=%b, expected data=%h trig=%b vld=%b",
                 i, out_if.data, out_if.trigger_vector, out_if.data_valid, got.data, got.trig, got.vld);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_up();
    test_hold();
    test_triangle_passthrough();
    test_prbs_const();
    test_trigger();
    test_mode_switch_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
